seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared BCD decoder, one-hot digit enables,
// double-buffered digits, anti-ghosting blank gap and optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    lz_suppress,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] RD_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam state_t        RESTART  = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t                         st, st_n;
    logic [CW-1:0]                  cnt, cnt_n;
    logic [IW-1:0]                  idx_n;
    logic [NUM_DIGITS-1:0][3:0]     act, act_n, sh, sh_n;
    logic                           pend, pend_n;
    logic                           commit, supp;
    logic [NUM_DIGITS-1:0]          zhi;
    logic [NUM_DIGITS-1:0]          en_n;
    logic [3:0]                     bcd_n;
    logic                           fd_n;

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        idx_n  = digit_idx;
        commit = (st == SHOW) && (cnt == RD_LAST) && (digit_idx == IDX_LAST);
        if (!enable) begin
            st_n  = IDLE;
            cnt_n = '0;
            idx_n = '0;
        end else begin
            case (st)
                IDLE: begin
                    st_n  = RESTART;
                    cnt_n = '0;
                    idx_n = '0;
                end
                BLANK: begin
                    if (cnt == BL_LAST) begin
                        st_n  = SHOW;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == RD_LAST) begin
                        st_n  = RESTART;
                        cnt_n = '0;
                        idx_n = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    st_n  = IDLE;
                    cnt_n = '0;
                    idx_n = '0;
                end
            endcase
        end
    end

    // A load landing on the commit cycle goes straight to active and leaves nothing pending.
    always_comb begin
        act_n  = act;
        sh_n   = sh;
        pend_n = pend;
        if (commit) begin
            if (load)      act_n = bcd_in;
            else if (pend) act_n = sh;
            pend_n = 1'b0;
        end else if (load) begin
            sh_n   = bcd_in;
            pend_n = 1'b1;
        end
    end

    // Outputs are computed from the next state and next active buffer so they stay registered.
    always_comb begin
        zhi[NUM_DIGITS-1] = (act_n[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            zhi[i] = zhi[i+1] && (act_n[i] == 4'h0);
        supp  = lz_suppress && (idx_n != '0) && zhi[idx_n];
        en_n  = '0;
        bcd_n = 4'hF;
        if (st_n != IDLE && !supp) begin
            bcd_n = act_n[idx_n];
            if (st_n == SHOW) en_n[idx_n] = 1'b1;
        end
        fd_n = (st_n == SHOW) && (cnt_n == RD_LAST) && (idx_n == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            cnt        <= '0;
            digit_idx  <= '0;
            act        <= '1;
            sh         <= '1;
            pend       <= 1'b0;
            digit_en   <= '0;
            bcd_out    <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            digit_idx  <= idx_n;
            act        <= act_n;
            sh         <= sh_n;
            pend       <= pend_n;
            digit_en   <= en_n;
            bcd_out    <= bcd_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-cycle expected outputs are queued as stimulus is
// planned and popped at each falling edge.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FR = ND * (BC + RD);

    typedef struct packed {
        logic [ND-1:0] en;
        logic [3:0]    bcd;
        logic [1:0]    idx;
        logic          fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   bcd_in = '0;
    logic          lz_suppress = 1'b0;
    logic [3:0]    bcd_out;
    logic [ND-1:0] digit_en;
    logic [1:0]    digit_idx;
    logic          frame_done;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in),
        .lz_suppress(lz_suppress), .bcd_out(bcd_out), .digit_en(digit_en),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected view of one frame of value val; only the first upto cycles are queued.
    task automatic push_frame(input logic [15:0] val, input bit lz, input int upto);
        int   n;
        bit   sp;
        logic [3:0] code;
        logic [ND-1:0] oh;
        n = 0;
        for (int d = 0; d < ND; d++) begin
            sp   = lz && (d > 0) && ((val >> (4 * d)) == 16'h0);
            code = sp ? 4'hF : val[4*d +: 4];
            oh   = sp ? '0 : ND'(1 << d);
            for (int b = 0; b < BC; b++) begin
                if (n < upto) exp_q.push_back('{'0, code, 2'(d), 1'b0});
                n++;
            end
            for (int s = 0; s < RD; s++) begin
                if (n < upto) exp_q.push_back('{oh, code, 2'(d), (d == ND - 1) && (s == RD - 1)});
                n++;
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{'0, 4'hF, 2'd0, 1'b0});
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({digit_en, bcd_out, digit_idx, frame_done} !== {4'h0, 4'hF, 2'd0, 1'b0})
            $display("FAIL reset got en=%h bcd=%h idx=%0d fd=%b", digit_en, bcd_out, digit_idx, frame_done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(2);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL idle c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
        end
    endtask

    task automatic test_scan_order();
        load = 1'b1; bcd_in = 16'h1234;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        push_frame(16'hFFFF, 0, FR);
        push_frame(16'h1234, 0, FR);
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL scan_order c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
        end
    endtask

    task automatic test_no_tearing();
        push_frame(16'h1234, 0, FR);
        push_frame(16'h5678, 0, FR);
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL no_tearing c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
            if (c == 7) begin load = 1'b1; bcd_in = 16'h5678; end
            if (c == 8) load = 1'b0;
        end
    endtask

    task automatic test_leading_zero();
        push_frame(16'h5678, 0, FR);
        push_frame(16'h0045, 1, FR);
        push_frame(16'h0000, 1, FR);
        push_frame(16'h0000, 0, FR);
        for (int c = 0; c < 4 * FR; c++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL leading_zero c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
            case (c)
                3:  begin load = 1'b1; bcd_in = 16'h0045; end
                23: begin load = 1'b1; bcd_in = 16'h0000; end
                63: begin load = 1'b1; bcd_in = 16'h1234; end
                4, 24, 64: load = 1'b0;
                19: lz_suppress = 1'b1;
                59: lz_suppress = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_enable_drop();
        push_frame(16'h1234, 0, 13);
        push_idle(3);
        push_frame(16'h1234, 0, FR);
        for (int c = 0; c < 16 + FR; c++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL enable_drop c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
            if (c == 12) enable = 1'b0;
            if (c == 15) enable = 1'b1;
        end
    endtask

    // Entered right after the frame_done cycle was observed, so load is high on the commit cycle.
    task automatic test_load_on_commit();
        load = 1'b1; bcd_in = 16'h9999;
        push_frame(16'h9999, 0, FR);
        push_frame(16'h9999, 0, FR);
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            load = 1'b0;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL load_on_commit c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        push_frame(16'h9999, 0, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL pre_reset c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({digit_en, bcd_out, digit_idx, frame_done} !== {4'h0, 4'hF, 2'd0, 1'b0})
            $display("FAIL async_reset got en=%h bcd=%h idx=%0d fd=%b", digit_en, bcd_out, digit_idx, frame_done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'hFFFF, 0, FR);
        push_frame(16'hFFFF, 0, FR);
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({digit_en, bcd_out, digit_idx, frame_done} !== e)
                $display("FAIL post_reset c=%0d got %h exp %h", c, {digit_en, bcd_out, digit_idx, frame_done}, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_no_tearing();
        test_leading_zero();
        test_enable_drop();
        test_load_on_commit();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
